// File: rtl/spi_settings_responder_if.sv
// spi_settings_responder_if: SPI pins, settings-write bus and readback bus of the SPI settings responder.
// Latency: none; plain wires.
// Backpressure: none; the slave modport is the responder side, the master modport is the board/host side.
// Signals: spi_sclk/spi_sen/spi_mosi in, spi_miso out; set_stb/set_addr/set_data write strobe;
//          rb_req/rb_addr request, rb_stb/rb_data response; busy and frame_err status.
// Optional: SPI_RESP_MISO_OE_EN adds spi_miso_oe (responder drives the shared miso line while high).
interface spi_settings_responder_if;
  logic        spi_sclk;
  logic        spi_sen;
  logic        spi_mosi;
  logic        spi_miso;
`ifdef SPI_RESP_MISO_OE_EN
  logic        spi_miso_oe;
`endif
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        rb_req;
  logic [7:0]  rb_addr;
  logic        rb_stb;
  logic [63:0] rb_data;
  logic        busy;
  logic        frame_err;

`ifdef SPI_RESP_MISO_OE_EN
  modport slave (
    input  spi_sclk, spi_sen, spi_mosi, rb_stb, rb_data,
    output spi_miso, spi_miso_oe, set_stb, set_addr, set_data, rb_req, rb_addr, busy, frame_err
  );
  modport master (
    output spi_sclk, spi_sen, spi_mosi, rb_stb, rb_data,
    input  spi_miso, spi_miso_oe, set_stb, set_addr, set_data, rb_req, rb_addr, busy, frame_err
  );
`else
  modport slave (
    input  spi_sclk, spi_sen, spi_mosi, rb_stb, rb_data,
    output spi_miso, set_stb, set_addr, set_data, rb_req, rb_addr, busy, frame_err
  );
  modport master (
    output spi_sclk, spi_sen, spi_mosi, rb_stb, rb_data,
    input  spi_miso, set_stb, set_addr, set_data, rb_req, rb_addr, busy, frame_err
  );
`endif
endinterface

// File: rtl/spi_settings_responder.sv
// spi_settings_responder: SPI mode-0 target turning frames into settings writes and readback reads.
// Latency: rb_req 1 clk after the 16th detected sclk rise; set_stb 2 clk after the 48th detected rise.
// Backpressure: none; the SPI master paces the frame, late readback data is replaced by 32'h0BADC0DE.
// Ports: clk, reset_n (async, active low); bus (slave modport): SPI pins, set_* write strobe,
//        rb_* readback handshake, busy, frame_err. Optional macro SPI_RESP_MISO_OE_EN adds bus.spi_miso_oe.
// Parameters: SYNC_STAGES (2-3) pin synchronizer depth, DUMMY_BITS (4-16) read turnaround bits.
module spi_settings_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_BITS  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  spi_settings_responder_if.slave  bus
);
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_WDATA, ST_RB_WAIT, ST_RDATA, ST_DONE} state_t;

  localparam logic [5:0]  LAST_HDR   = 6'd15;
  localparam logic [5:0]  LAST_WORD  = 6'd31;
  localparam logic [5:0]  LAST_DUMMY = 6'(DUMMY_BITS);
  localparam logic [31:0] BAD_WORD   = 32'h0BADC0DE;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   armed_q, armed_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [31:0]            sr_q, sr_d;
  logic                   got_q, got_d;
  logic                   hi_q, hi_d;
  logic [7:0]             addr_q, addr_d;
  logic                   wr_pend_q, wr_pend_d;
  logic                   miso_q, miso_d;
  logic                   set_stb_q, set_stb_d;
  logic [7:0]             set_addr_q, set_addr_d;
  logic [31:0]            set_data_q, set_data_d;
  logic                   rb_req_q, rb_req_d;
  logic [7:0]             rb_addr_q, rb_addr_d;
  logic                   frame_err_q, frame_err_d;

  logic        sclk_s, sen_s, mosi_s, rise, fall;
  logic        hdr_done, wr_done, dummy_end, rd_done;
  logic [7:0]  addr_in;
  logic [31:0] rb_sel, rd_word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sen_s  = sen_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_hist_q;
  assign fall   = ~sclk_s & sclk_hist_q;

  assign hdr_done  = (state_q == ST_HDR)     && rise && (cnt_q == LAST_HDR);
  assign wr_done   = (state_q == ST_WDATA)   && rise && (cnt_q == LAST_WORD);
  assign dummy_end = (state_q == ST_RB_WAIT) && fall && (cnt_q == LAST_DUMMY);
  assign rd_done   = (state_q == ST_RDATA)   && rise && (cnt_q == LAST_WORD);

  // Header is {rnw, hi, 6'b0, addr}; its last bit is still on mosi_s when hdr_done fires.
  assign addr_in = {sr_q[6:0], mosi_s};
  assign rb_sel  = hi_q ? bus.rb_data[63:32] : bus.rb_data[31:0];
  // A strobe coinciding with the last dummy fall still counts as real data.
  assign rd_word = got_q ? sr_q : (bus.rb_stb ? rb_sel : BAD_WORD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      sen_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      got_q       <= 1'b0;
      hi_q        <= 1'b0;
      addr_q      <= '0;
      wr_pend_q   <= 1'b0;
      miso_q      <= 1'b0;
      set_stb_q   <= 1'b0;
      set_addr_q  <= '0;
      set_data_q  <= '0;
      rb_req_q    <= 1'b0;
      rb_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      sen_sync_q  <= sen_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      got_q       <= got_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      wr_pend_q   <= wr_pend_d;
      miso_q      <= miso_d;
      set_stb_q   <= set_stb_d;
      set_addr_q  <= set_addr_d;
      set_data_q  <= set_data_d;
      rb_req_q    <= rb_req_d;
      rb_addr_q   <= rb_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
    sen_sync_d  = {sen_sync_q[SYNC_STAGES-2:0], bus.spi_sen};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    sclk_hist_d = sclk_s;
  end

  // Next-state logic. The synchronized enable resets to "low", so a frame may only start
  // once enable has been seen high at least once since reset (armed_q).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!sen_s && armed_q) state_d = ST_HDR;
      ST_HDR:     if (sen_s) state_d = ST_IDLE;
                  else if (hdr_done) state_d = sr_q[14] ? ST_RB_WAIT : ST_WDATA;
      ST_WDATA:   if (sen_s) state_d = ST_IDLE;
                  else if (wr_done) state_d = ST_DONE;
      ST_RB_WAIT: if (sen_s) state_d = ST_IDLE;
                  else if (dummy_end) state_d = ST_RDATA;
      ST_RDATA:   if (sen_s) state_d = ST_IDLE;
                  else if (rd_done) state_d = ST_DONE;
      ST_DONE:    if (sen_s) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    got_d       = got_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    wr_pend_d   = 1'b0;
    miso_d      = 1'b0;
    rb_req_d    = 1'b0;
    rb_addr_d   = rb_addr_q;
    frame_err_d = 1'b0;
    armed_d     = armed_q | sen_s;
    // Write commit is one cycle behind the last data rise so sr_q holds the full word.
    set_stb_d   = wr_pend_q;
    set_addr_d  = wr_pend_q ? addr_q : set_addr_q;
    set_data_d  = wr_pend_q ? sr_q : set_data_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sr_d  = '0;
        got_d = 1'b0;
      end
      ST_HDR: begin
        if (sen_s) begin
          frame_err_d = 1'b1;
        end else if (rise) begin
          sr_d  = {sr_q[30:0], mosi_s};
          cnt_d = cnt_q + 6'd1;
          if (hdr_done) begin
            cnt_d  = '0;
            sr_d   = '0;
            addr_d = addr_in;
            hi_d   = sr_q[13];
            if (sr_q[14]) begin
              rb_req_d  = 1'b1;
              rb_addr_d = addr_in;
            end
          end
        end
      end
      ST_WDATA: begin
        if (sen_s) begin
          frame_err_d = 1'b1;
        end else if (rise) begin
          sr_d  = {sr_q[30:0], mosi_s};
          cnt_d = cnt_q + 6'd1;
          if (wr_done) begin
            cnt_d     = '0;
            wr_pend_d = 1'b1;
          end
        end
      end
      ST_RB_WAIT: begin
        if (sen_s) begin
          frame_err_d = 1'b1;
        end else begin
          if (rise) cnt_d = cnt_q + 6'd1;
          if (bus.rb_stb && !got_q) begin
            sr_d  = rb_sel;
            got_d = 1'b1;
          end
          // First data bit goes out on the fall that closes the turnaround.
          if (dummy_end) begin
            miso_d      = rd_word[31];
            sr_d        = {rd_word[30:0], 1'b0};
            cnt_d       = '0;
            frame_err_d = ~(got_q | bus.rb_stb);
          end
        end
      end
      ST_RDATA: begin
        if (sen_s) begin
          frame_err_d = 1'b1;
        end else begin
          miso_d = miso_q;
          if (fall) begin
            miso_d = sr_q[31];
            sr_d   = {sr_q[30:0], 1'b0};
          end
          if (rise) begin
            cnt_d = cnt_q + 6'd1;
            if (rd_done) begin
              cnt_d  = '0;
              miso_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.spi_miso  = miso_q;
  assign bus.set_stb   = set_stb_q;
  assign bus.set_addr  = set_addr_q;
  assign bus.set_data  = set_data_q;
  assign bus.rb_req    = rb_req_q;
  assign bus.rb_addr   = rb_addr_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.frame_err = frame_err_q;
`ifdef SPI_RESP_MISO_OE_EN
  assign bus.spi_miso_oe = ~sen_s & (state_q != ST_IDLE);
`endif
endmodule

// File: tb/tb_spi_settings_responder.sv
// tb_spi_settings_responder: randomized frames against a readback-memory reference model.
// Stimulus pushes expected writes, readback requests, miso words and frame errors into queues;
// monitors pop and compare whenever the responder presents the matching output.
module tb_spi_settings_responder;
  localparam int SYNC_STAGES = 2;
  localparam int DUMMY_BITS  = 8;
  localparam int HALF        = 5;
  localparam int RD_BITS     = 16 + DUMMY_BITS + 32;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_settings_responder_if bus();

  spi_settings_responder #(
    .SYNC_STAGES(SYNC_STAGES),
    .DUMMY_BITS (DUMMY_BITS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cur_frame = 0;
  int          rb_delay = -1;
  logic [63:0] rb_mem [256];
  wr_t         exp_set [$];
  logic [7:0]  exp_rb [$];
  logic [31:0] exp_miso [$];
  int          exp_err [$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic logic [63:0] out_vec();
    return {11'h0, bus.set_stb, bus.set_addr, bus.set_data, bus.rb_req, bus.rb_addr,
            bus.busy, bus.frame_err, bus.spi_miso};
  endfunction

  // Reference model: the word the master must read back for one read frame.
  function automatic logic [31:0] model_read(input logic [7:0] a, input logic hi, input int dly);
    logic [63:0] w;
    if (dly < 0) return 32'h0BADC0DE;
    w = rb_mem[a];
    return hi ? w[63:32] : w[31:0];
  endfunction

  // Readback responder: first strobe carries the memory word, a later strobe carries junk.
  initial begin
    bus.rb_stb  = 1'b0;
    bus.rb_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.rb_req && rb_delay >= 0) begin
        repeat (rb_delay - 1) @(negedge clk);
        bus.rb_data = rb_mem[bus.rb_addr];
        bus.rb_stb  = 1'b1;
        @(negedge clk);
        bus.rb_stb  = 1'b0;
        bus.rb_data = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        bus.rb_stb  = 1'b1;
        @(negedge clk);
        bus.rb_stb  = 1'b0;
      end
    end
  end

  // Output monitor for the clk-domain strobes.
  wr_t        mon_w;
  logic [7:0] mon_a;
  int         mon_f;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.set_stb) begin
        check(exp_set.size() != 0, "set_stb_expected", {24'h0, bus.set_addr, bus.set_data}, 64'h0);
        if (exp_set.size() != 0) begin
          mon_w = exp_set.pop_front();
          check({bus.set_addr, bus.set_data} == mon_w, "set_write",
                {24'h0, bus.set_addr, bus.set_data}, {24'h0, mon_w});
        end
      end
      if (bus.rb_req) begin
        check(exp_rb.size() != 0, "rb_req_expected", 64'(bus.rb_addr), 64'h0);
        if (exp_rb.size() != 0) begin
          mon_a = exp_rb.pop_front();
          check(bus.rb_addr == mon_a, "rb_addr", 64'(bus.rb_addr), 64'(mon_a));
        end
      end
      if (bus.frame_err) begin
        check(exp_err.size() != 0, "frame_err_expected", 64'(cur_frame), 64'h0);
        if (exp_err.size() != 0) begin
          mon_f = exp_err.pop_front();
          check(mon_f == cur_frame, "frame_err_frame", 64'(cur_frame), 64'(mon_f));
        end
      end
    end
  end

  // SPI monitor: decodes the header from mosi, collects miso in the read data window.
  int          mb_n = 0;
  int          mb_stray = 0;
  logic [15:0] mb_hdr = '0;
  logic [31:0] mb_word = '0;
  logic [31:0] mb_exp;
  always @(posedge bus.spi_sclk or posedge bus.spi_sen) begin
    if (bus.spi_sen) begin
      if (mb_n >= RD_BITS && mb_hdr[15]) begin
        check(exp_miso.size() != 0, "miso_expected", 64'(mb_word), 64'h0);
        if (exp_miso.size() != 0) begin
          mb_exp = exp_miso.pop_front();
          check(mb_word == mb_exp, "miso_word", 64'(mb_word), 64'(mb_exp));
        end
      end
      if (mb_n > 0) check(mb_stray == 0, "miso_zero_outside_data", 64'(mb_stray), 64'h0);
      mb_n = 0; mb_stray = 0; mb_hdr = '0; mb_word = '0;
    end else begin
      mb_n++;
      if (mb_n <= 16) mb_hdr = {mb_hdr[14:0], bus.spi_mosi};
      if (mb_hdr[15] && mb_n > 16 + DUMMY_BITS && mb_n <= RD_BITS) mb_word = {mb_word[30:0], bus.spi_miso};
      else if (bus.spi_miso) mb_stray++;
    end
  end

  // One SPI frame; sclk period is 2*HALF clk. rst_at >= 0 pulses reset_n before that bit.
  task automatic spi_frame(input logic [15:0] hdr, input logic [31:0] wdat, input int nbits,
                           input int rst_at, input bit chk_lat);
    logic [47:0] bits;
    int          seen;
    bits = {hdr, wdat};
    bus.spi_sen = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = (i < 48) ? bits[47-i] : 1'($urandom);
      if (i == rst_at) begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check(out_vec() == 64'h0, "reset_mid_frame", out_vec(), 64'h0);
        reset_n = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b1;
      seen = 0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (seen == 0 && ((i == 15 && hdr[15] && bus.rb_req) || (i == 47 && !hdr[15] && bus.set_stb)))
          seen = k;
      end
      if (chk_lat && i == 15 && hdr[15])
        check(seen == SYNC_STAGES + 1, "rb_req_latency", 64'(seen), 64'(SYNC_STAGES + 1));
      if (chk_lat && i == 47 && !hdr[15])
        check(seen == SYNC_STAGES + 2, "set_stb_latency", 64'(seen), 64'(SYNC_STAGES + 2));
      if (i == 8) check(bus.busy == 1'b1, "busy_in_frame", 64'(bus.busy), 64'h1);
      bus.spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    bus.spi_sen = 1'b1;
    repeat (12) @(negedge clk);
    check(bus.busy == 1'b0, "busy_after_frame", 64'(bus.busy), 64'h0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic hi, input int extra);
    cur_frame++;
    exp_set.push_back({a, d});
    spi_frame({1'b0, hi, 6'b0, a}, d, 48 + extra, -1, 1'b1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic hi, input int dly, input int extra);
    cur_frame++;
    rb_delay = dly;
    exp_rb.push_back(a);
    exp_miso.push_back(model_read(a, hi, dly));
    if (dly < 0) exp_err.push_back(cur_frame);
    spi_frame({1'b1, hi, 6'b0, a}, $urandom, RD_BITS + extra, -1, 1'b1);
  endtask

  task automatic do_abort(input logic [7:0] a, input logic [31:0] d, input int nbits);
    cur_frame++;
    exp_err.push_back(cur_frame);
    spi_frame({1'b0, 1'b0, 6'b0, a}, d, nbits, -1, 1'b0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_sen  = 1'b1;
    bus.spi_mosi = 1'b0;
    for (int i = 0; i < 256; i++) rb_mem[i] = {$urandom, $urandom};
    rb_mem[8'h10] = 64'h1122334455667788;
    repeat (4) @(negedge clk);
    check(out_vec() == 64'h0, "reset_state", out_vec(), 64'h0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    do_write(8'hA5, 32'hDEADBEEF, 1'b0, 0);
    do_read(8'h10, 1'b0, 2, 0);
    do_read(8'h10, 1'b1, 2, 0);
    do_read(8'h33, 1'b0, -1, 0);
    do_abort(8'h5A, 32'hCAFEF00D, 20);
    do_write(8'h01, 32'h00000001, 1'b0, 0);

    // Reset for 3 clk at bit 30; the rest of that frame must be ignored.
    cur_frame++;
    spi_frame(16'h0077, 32'h12345678, 48, 29, 1'b0);
    do_write(8'h77, 32'h87654321, 1'b0, 0);

    for (int n = 0; n < 36; n++) begin
      case ($urandom_range(0, 3))
        0: do_write(8'($urandom), $urandom, 1'($urandom), $urandom_range(0, 3));
        1: do_read(8'($urandom), 1'($urandom), $urandom_range(1, 40), $urandom_range(0, 3));
        2: do_read(8'($urandom), 1'($urandom), -1, $urandom_range(0, 3));
        default: do_abort(8'($urandom), $urandom, $urandom_range(1, 47));
      endcase
    end

    repeat (20) @(negedge clk);
    check(exp_set.size() == 0, "set_queue_drained", 64'(exp_set.size()), 64'h0);
    check(exp_rb.size() == 0, "rb_queue_drained", 64'(exp_rb.size()), 64'h0);
    check(exp_miso.size() == 0, "miso_queue_drained", 64'(exp_miso.size()), 64'h0);
    check(exp_err.size() == 0, "err_queue_drained", 64'(exp_err.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
